// File: rtl/fg_dac_spi_tx_if.sv
// Sample, status and SPI pins of the DAC output stage, bundled as one port.
// The slave side is the DAC transmitter. The master side is whoever drives
// the sample strobe and watches the pins.
interface fg_dac_spi_tx_if #(
  parameter int BITWIDTH = 16
) ();
  logic                       strobe_i;
  logic signed [BITWIDTH-1:0] data_i;
  logic                       clr_overrun_i;
  logic                       busy_o;
  logic                       done_o;
  logic                       overrun_o;
  logic                       sclk_o;
  logic                       cs_n_o;
  logic                       mosi_o;

  modport slave (
    input  strobe_i, data_i, clr_overrun_i,
    output busy_o, done_o, overrun_o, sclk_o, cs_n_o, mosi_o
  );

  modport master (
    output strobe_i, data_i, clr_overrun_i,
    input  busy_o, done_o, overrun_o, sclk_o, cs_n_o, mosi_o
  );
endinterface

// File: rtl/fg_dac_spi_tx.sv
// SPI mode-0 transmitter for the function generator DAC. It captures one signed
// sample per strobe, can flip the MSB to produce offset-binary, and shifts the
// word out MSB first. Each bit gets CLK_DIV cycles with SCLK low and then
// CLK_DIV cycles with SCLK high. After the last bit, CS stays high for CLK_DIV
// cycles. All pin outputs come straight from flops.
module fg_dac_spi_tx #(
  parameter int BITWIDTH      = 16,
  parameter int CLK_DIV       = 2,
  parameter bit OFFSET_BINARY = 1'b1
) (
  input logic              clk_i,
  input logic              nrst_i,
  fg_dac_spi_tx_if.slave   bus
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(BITWIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(BITWIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} state_t;

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]       div_q, div_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;

  logic [BITWIDTH-1:0] load_word;
  logic                div_last;

  // Word as it goes on the wire. Flipping only the MSB turns two's
  // complement into offset-binary without any other arithmetic.
  assign load_word = OFFSET_BINARY ? {~bus.data_i[BITWIDTH-1], bus.data_i[BITWIDTH-2:0]}
                                   : bus.data_i;
  assign div_last  = (div_q == DIV_LAST);

  // State and output registers; cs_n returns high as soon as reset asserts
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic. Each phase runs for CLK_DIV cycles, counted by div_q.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;

    // A dropped strobe takes priority over a clear in the same cycle
    if (bus.strobe_i && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (bus.clr_overrun_i) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.strobe_i) begin
          shreg_d   = load_word;
          bit_cnt_d = '0;
          div_d     = '0;
          sclk_d    = 1'b0;
          cs_n_d    = 1'b0;
          mosi_d    = load_word[BITWIDTH-1];
          busy_d    = 1'b1;
          state_d   = LOW;
        end
      end
      LOW: begin
        if (div_last) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      HIGH: begin
        if (div_last) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_cnt_q != BIT_LAST) begin
            // Next bit changes together with the SCLK falling edge
            shreg_d   = shreg_q << 1;
            mosi_d    = shreg_q[BITWIDTH-2];
            bit_cnt_d = bit_cnt_q + CW'(1);
            state_d   = LOW;
          end else begin
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            state_d = GAP;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      GAP: begin
        if (div_last) begin
          div_d     = '0;
          shreg_d   = '0;
          bit_cnt_d = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.overrun_o = overrun_q;
  assign bus.sclk_o    = sclk_q;
  assign bus.cs_n_o    = cs_n_q;
  assign bus.mosi_o    = mosi_q;

endmodule

// File: tb/tb_fg_dac_spi_tx.sv
// Bench for fg_dac_spi_tx. It uses three instances: A is 16 bit, div 2,
// offset-binary; B is 16 bit, div 2, raw; C is 8 bit, div 1, raw. Single
// frames come from a vector table. Hand-written sequences cover back-to-back
// frames, overrun set/clear, and reset in the middle of a frame.
module tb_fg_dac_spi_tx;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  int          sel;
  logic        strobe;
  logic        clr;
  logic [15:0] data;

  fg_dac_spi_tx_if #(.BITWIDTH(16)) ifa ();
  fg_dac_spi_tx_if #(.BITWIDTH(16)) ifb ();
  fg_dac_spi_tx_if #(.BITWIDTH(8))  ifc ();

  assign ifa.strobe_i      = strobe && (sel == 0);
  assign ifb.strobe_i      = strobe && (sel == 1);
  assign ifc.strobe_i      = strobe && (sel == 2);
  assign ifa.clr_overrun_i = clr && (sel == 0);
  assign ifb.clr_overrun_i = clr && (sel == 1);
  assign ifc.clr_overrun_i = clr && (sel == 2);
  assign ifa.data_i        = data;
  assign ifb.data_i        = data;
  assign ifc.data_i        = data[7:0];

  fg_dac_spi_tx #(.BITWIDTH(16), .CLK_DIV(2), .OFFSET_BINARY(1'b1)) u_a (
    .clk_i(clk), .nrst_i(nrst), .bus(ifa));
  fg_dac_spi_tx #(.BITWIDTH(16), .CLK_DIV(2), .OFFSET_BINARY(1'b0)) u_b (
    .clk_i(clk), .nrst_i(nrst), .bus(ifb));
  fg_dac_spi_tx #(.BITWIDTH(8), .CLK_DIV(1), .OFFSET_BINARY(1'b0)) u_c (
    .clk_i(clk), .nrst_i(nrst), .bus(ifc));

  logic o_busy, o_done, o_ov, o_sclk, o_cs_n, o_mosi;
  always_comb begin
    o_busy = ifa.busy_o; o_done = ifa.done_o; o_ov = ifa.overrun_o;
    o_sclk = ifa.sclk_o; o_cs_n = ifa.cs_n_o; o_mosi = ifa.mosi_o;
    if (sel == 1) begin
      o_busy = ifb.busy_o; o_done = ifb.done_o; o_ov = ifb.overrun_o;
      o_sclk = ifb.sclk_o; o_cs_n = ifb.cs_n_o; o_mosi = ifb.mosi_o;
    end else if (sel == 2) begin
      o_busy = ifc.busy_o; o_done = ifc.done_o; o_ov = ifc.overrun_o;
      o_sclk = ifc.sclk_o; o_cs_n = ifc.cs_n_o; o_mosi = ifc.mosi_o;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] word;
    int busy_cnt, cs_low, gap_hi, pulses, bad_hi, bad_lo, mosi_bad;
    logic done_end, cs_n_end, ov_end;
    logic ov_a_before, ov_a_after, ov_b_after;
    logic timeout;
  } res_t;

  // Strobes one frame in the current cycle and follows it sample by sample.
  // Returns in the first idle cycle, which is the done cycle. data_i is
  // inverted right after accept so that a late change would show up.
  // drop_a strobes mid-frame; drop_b strobes together with clr_overrun.
  task automatic run_frame(input logic [15:0] d, input int div,
                           input int drop_a, input int drop_b, output res_t r);
    logic prev_sclk, prev_mosi;
    int   hi_run, lo_run, c;
    r = '{default: 0};
    strobe = 1'b1; data = d;
    step();
    strobe = 1'b0; data = ~d;
    prev_sclk = 1'b0; prev_mosi = o_mosi; hi_run = 0; lo_run = 0; c = 0;
    while (o_busy) begin
      if (c >= 400) begin
        r.timeout = 1'b1;
        break;
      end
      r.busy_cnt++;
      if (!o_cs_n) r.cs_low++; else r.gap_hi++;
      if (c > 0 && o_mosi != prev_mosi && !(prev_sclk && !o_sclk)) r.mosi_bad++;
      if (!prev_sclk && o_sclk) begin
        r.word = {r.word[14:0], o_mosi};
        r.pulses++;
        if (lo_run != div) r.bad_lo++;
        lo_run = 0;
      end
      if (prev_sclk && !o_sclk) begin
        if (hi_run != div) r.bad_hi++;
        hi_run = 0;
      end
      if (o_sclk) hi_run++;
      else if (!o_cs_n) lo_run++;
      if (c == drop_a)     r.ov_a_before = o_ov;
      if (c == drop_a + 1) r.ov_a_after  = o_ov;
      if (c == drop_b + 1) r.ov_b_after  = o_ov;
      strobe = (c == drop_a) || (c == drop_b);
      clr    = (c == drop_b);
      prev_sclk = o_sclk; prev_mosi = o_mosi;
      step();
      c++;
    end
    strobe = 1'b0; clr = 1'b0;
    r.done_end = o_done; r.cs_n_end = o_cs_n; r.ov_end = o_ov;
  endtask

  typedef struct {
    int          sel;
    logic [15:0] din;
    logic [15:0] exp_word;
    int          div;
    int          exp_busy;
    int          exp_cs;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[6];
  res_t r, r2;
  int   falls;
  logic prev;

  initial begin
    // Expected values: busy = 2*DIV*BITS + DIV, CS low = 2*DIV*BITS
    vecs[0] = '{0, 16'h0000, 16'h8000, 2, 66, 64, 16};
    vecs[1] = '{0, 16'h1234, 16'h9234, 2, 66, 64, 16};
    vecs[2] = '{0, 16'hFFFF, 16'h7FFF, 2, 66, 64, 16};
    vecs[3] = '{1, 16'h1234, 16'h1234, 2, 66, 64, 16};
    vecs[4] = '{2, 16'h00A5, 16'h00A5, 1, 17, 16, 8};
    vecs[5] = '{2, 16'h003C, 16'h003C, 1, 17, 16, 8};

    nrst = 1'b0; sel = 0; strobe = 1'b0; clr = 1'b0; data = '0;
    repeat (3) step();
    check("rst_cs_n", o_cs_n, 1); check("rst_sclk", o_sclk, 0);
    check("rst_mosi", o_mosi, 0); check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0); check("rst_ov", o_ov, 0);
    nrst = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      sel = vecs[i].sel;
      step();
      run_frame(vecs[i].din, vecs[i].div, -1, -1, r);
      $display("vec %0d: inst %0d din %04h -> word %04h busy %0d cs_low %0d pulses %0d",
               i, sel, vecs[i].din, r.word, r.busy_cnt, r.cs_low, r.pulses);
      check("vec_timeout", r.timeout, 0);
      check("vec_word", r.word, vecs[i].exp_word);
      check("vec_busy", r.busy_cnt, vecs[i].exp_busy);
      check("vec_cs_low", r.cs_low, vecs[i].exp_cs);
      check("vec_gap", r.gap_hi, vecs[i].div);
      check("vec_pulses", r.pulses, vecs[i].exp_pulses);
      check("vec_hi_width", r.bad_hi, 0);
      check("vec_lo_width", r.bad_lo, 0);
      check("vec_mosi_stable", r.mosi_bad, 0);
      check("vec_done", r.done_end, 1);
      check("vec_ov", r.ov_end, 0);
      step();
      check("vec_done_1cyc", o_done, 0);
    end

    // Back-to-back: the second strobe lands in the done cycle of the first
    sel = 0;
    step();
    run_frame(16'h8000, 2, -1, -1, r);
    check("b2b_done1", r.done_end, 1);
    check("b2b_cs_hi_done", r.cs_n_end, 1);
    run_frame(16'h7FFF, 2, -1, -1, r2);
    $display("b2b: words %04h %04h gaps %0d %0d ov %0b", r.word, r2.word, r.gap_hi, r2.gap_hi, r2.ov_end);
    check("b2b_word1", r.word, 16'h0000);
    check("b2b_word2", r2.word, 16'hFFFF);
    check("b2b_gap1", r.gap_hi, 2);
    check("b2b_busy2", r2.busy_cnt, 66);
    check("b2b_done2", r2.done_end, 1);
    check("b2b_ov", r2.ov_end, 0);
    step();

    // Strobe dropped 10 cycles after accept
    run_frame(16'h1234, 2, 10, -1, r);
    $display("overrun: word %04h ov before %0b after %0b end %0b", r.word, r.ov_a_before, r.ov_a_after, r.ov_end);
    check("ovr_before", r.ov_a_before, 0);
    check("ovr_after", r.ov_a_after, 1);
    check("ovr_word", r.word, 16'h9234);
    check("ovr_busy", r.busy_cnt, 66);
    check("ovr_sticky", r.ov_end, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    $display("overrun clear: ov %0b", o_ov);
    check("ovr_clear", o_ov, 0);

    // A clear arriving with a new drop leaves overrun set
    run_frame(16'h0001, 2, 5, 20, r);
    $display("overrun set-wins: ov %0b word %04h", r.ov_b_after, r.word);
    check("ovr_setwins_a", r.ov_a_after, 1);
    check("ovr_setwins_b", r.ov_b_after, 1);
    check("ovr_setwins_word", r.word, 16'h8001);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("ovr_clear2", o_ov, 0);

    // Reset after the fifth SCLK pulse
    strobe = 1'b1; data = 16'h1234;
    step();
    strobe = 1'b0;
    falls = 0; prev = 1'b0;
    for (int c = 0; c < 200 && falls < 5; c++) begin
      if (prev && !o_sclk) falls++;
      prev = o_sclk;
      if (falls < 5) step();
    end
    check("rstmid_reached", falls, 5);
    check("rstmid_busy_pre", o_busy, 1);
    #2 nrst = 1'b0;
    #1;
    $display("reset mid-frame: cs_n %0b sclk %0b busy %0b mosi %0b", o_cs_n, o_sclk, o_busy, o_mosi);
    check("rstmid_cs_n", o_cs_n, 1);
    check("rstmid_sclk", o_sclk, 0);
    check("rstmid_busy", o_busy, 0);
    check("rstmid_mosi", o_mosi, 0);
    falls = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (o_done) falls++;
    end
    nrst = 1'b1;
    step();
    if (o_done) falls++;
    check("rstmid_no_done", falls, 0);
    run_frame(16'h5A5A, 2, -1, -1, r);
    $display("after reset: word %04h busy %0d", r.word, r.busy_cnt);
    check("rstmid_word", r.word, 16'hDA5A);
    check("rstmid_busy_cnt", r.busy_cnt, 66);
    check("rstmid_done", r.done_end, 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
